// File: rtl/alu_muldiv_pkg.sv
// ============================================================================
// alu_muldiv_pkg : opcode encoding and width-generic bit-count helpers
// Revision: 1.0
// ============================================================================
`default_nettype none

package alu_muldiv_pkg;

    localparam int MAX_XLEN = 64;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLL    = 5'd2,
        ALU_SLT    = 5'd3,
        ALU_SLTU   = 5'd4,
        ALU_XOR    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_OR     = 5'd8,
        ALU_AND    = 5'd9,
        ALU_CTZ    = 5'd10,
        ALU_CLZ    = 5'd11,
        ALU_CPOP   = 5'd12,
        ALU_MUL    = 5'd16,
        ALU_MULH   = 5'd17,
        ALU_MULHSU = 5'd18,
        ALU_MULHU  = 5'd19,
        ALU_DIV    = 5'd20,
        ALU_DIVU   = 5'd21,
        ALU_REM    = 5'd22,
        ALU_REMU   = 5'd23
    } alu_op_e;

    // Multiply/divide group occupies encodings 16..23.
    function automatic logic is_muldiv(logic [4:0] sel);
        return sel[4:3] == 2'b10;
    endfunction

    function automatic int cpop(logic [MAX_XLEN-1:0] v, int xlen);
        int n;
        n = 0;
        for (int i = 0; i < MAX_XLEN; i++) begin
            if (i < xlen && v[i]) n++;
        end
        return n;
    endfunction

    function automatic int ctz(logic [MAX_XLEN-1:0] v, int xlen);
        int   n;
        logic found;
        n     = 0;
        found = 1'b0;
        for (int i = 0; i < MAX_XLEN; i++) begin
            if (i < xlen && !found) begin
                if (v[i]) found = 1'b1;
                else      n++;
            end
        end
        return n;
    endfunction

    function automatic int clz(logic [MAX_XLEN-1:0] v, int xlen);
        int   n;
        logic found;
        n     = 0;
        found = 1'b0;
        for (int i = MAX_XLEN - 1; i >= 0; i--) begin
            if (i < xlen && !found) begin
                if (v[i]) found = 1'b1;
                else      n++;
            end
        end
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_muldiv_iter.sv
// ============================================================================
// alu_muldiv_iter : radix-2 shift-add multiplier / restoring divider datapath
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_muldiv_iter
    import alu_muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int SEL_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start,
    input  logic             step,
    input  logic [SEL_W-1:0] sel,
    input  logic [XLEN-1:0]  op1,
    input  logic [XLEN-1:0]  op2,
    output logic             last,
    output logic [XLEN-1:0]  result
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    logic [2*XLEN-1:0] acc, acc_src, acc_next, prod;
    logic [XLEN-1:0]   b_reg, b_src, abs1, abs2, quo, rem;
    logic [XLEN:0]     add_sum, shl, trial;
    logic [CNT_W-1:0]  cnt;
    logic              is_div, hi_sel, rem_sel, neg_q, neg_r;
    logic              sign1, sign2, ld_div, div_mode;

    // The first step is taken on the load edge itself, which keeps the
    // iterative latency at XLEN+1 including the FIX cycle.
    always_comb begin
        sign1    = op1[XLEN-1] && (sel == ALU_MULH || sel == ALU_MULHSU ||
                                   sel == ALU_DIV  || sel == ALU_REM);
        sign2    = op2[XLEN-1] && (sel == ALU_MULH || sel == ALU_DIV || sel == ALU_REM);
        abs1     = sign1 ? -op1 : op1;
        abs2     = sign2 ? -op2 : op2;
        ld_div   = (sel == ALU_DIV) || (sel == ALU_DIVU) || (sel == ALU_REM) || (sel == ALU_REMU);
        acc_src  = start ? {{XLEN{1'b0}}, abs1} : acc;
        b_src    = start ? abs2 : b_reg;
        div_mode = start ? ld_div : is_div;
        add_sum  = {1'b0, acc_src[2*XLEN-1:XLEN]} +
                   (acc_src[0] ? {1'b0, b_src} : {(XLEN+1){1'b0}});
        shl      = acc_src[2*XLEN-1:XLEN-1];
        trial    = shl - {1'b0, b_src};
        if (div_mode) begin
            if (!trial[XLEN]) acc_next = {trial[XLEN-1:0], acc_src[XLEN-2:0], 1'b1};
            else              acc_next = {shl[XLEN-1:0], acc_src[XLEN-2:0], 1'b0};
        end else begin
            acc_next = {add_sum, acc_src[XLEN-1:1]};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc     <= '0;
            b_reg   <= '0;
            cnt     <= '0;
            is_div  <= 1'b0;
            hi_sel  <= 1'b0;
            rem_sel <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
        end else if (start) begin
            acc     <= acc_next;
            b_reg   <= abs2;
            cnt     <= CNT_W'(XLEN - 1);
            is_div  <= ld_div;
            hi_sel  <= (sel == ALU_MULH) || (sel == ALU_MULHSU) || (sel == ALU_MULHU);
            rem_sel <= (sel == ALU_REM) || (sel == ALU_REMU);
            neg_q   <= sign1 ^ sign2;
            neg_r   <= sign1;
        end else if (step && cnt != '0) begin
            acc     <= acc_next;
            cnt     <= cnt - CNT_W'(1);
        end
    end

    assign last = step && (cnt == CNT_W'(1));

    // Remainder follows the dividend sign; quotient/product follow sign1^sign2.
    always_comb begin
        prod = neg_q ? -acc : acc;
        quo  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        if (is_div) result = rem_sel ? rem : quo;
        else        result = hi_sel ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    end

endmodule

`default_nettype wire

// File: rtl/alu_muldiv.sv
// ============================================================================
// alu_muldiv : handshaked RV32I/Zbb ALU plus iterative RV32M multiply/divide
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_muldiv
    import alu_muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int SEL_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [SEL_W-1:0] sel_i,
    input  logic [XLEN-1:0]  op1_i,
    input  logic [XLEN-1:0]  op2_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [XLEN-1:0]  result_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ITER = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam int              SH_W    = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]          state;
    logic [XLEN-1:0]     result, base_res, short_res, imm_res, iter_result;
    logic [MAX_XLEN-1:0] op1_ext;
    logic [SH_W-1:0]     shamt;
    logic                accept, muldiv, div_op, rem_op, signed_div;
    logic                div_zero, div_ovf, short_cut, go_iter, iter_last;

    assign ready_o  = (state == IDLE);
    assign valid_o  = (state == DONE);
    assign result_o = result;
    assign accept   = valid_i && ready_o;
    assign shamt    = op2_i[SH_W-1:0];

    always_comb begin
        op1_ext              = '0;
        op1_ext[XLEN-1:0]    = op1_i;
        base_res             = '0;
        case (sel_i)
            ALU_ADD:  base_res = op1_i + op2_i;
            ALU_SUB:  base_res = op1_i - op2_i;
            ALU_SLL:  base_res = op1_i << shamt;
            ALU_SRL:  base_res = op1_i >> shamt;
            ALU_SRA:  base_res = $signed(op1_i) >>> shamt;
            ALU_SLT:  base_res[0] = $signed(op1_i) < $signed(op2_i);
            ALU_SLTU: base_res[0] = op1_i < op2_i;
            ALU_XOR:  base_res = op1_i ^ op2_i;
            ALU_OR:   base_res = op1_i | op2_i;
            ALU_AND:  base_res = op1_i & op2_i;
            ALU_CTZ:  base_res = XLEN'(ctz(op1_ext, XLEN));
            ALU_CLZ:  base_res = XLEN'(clz(op1_ext, XLEN));
            ALU_CPOP: base_res = XLEN'(cpop(op1_ext, XLEN));
            default:  base_res = '0;
        endcase
    end

    // Divide-by-zero and signed overflow bypass the iterative engine.
    always_comb begin
        muldiv     = is_muldiv(sel_i);
        div_op     = (sel_i == ALU_DIV) || (sel_i == ALU_DIVU) ||
                     (sel_i == ALU_REM) || (sel_i == ALU_REMU);
        rem_op     = (sel_i == ALU_REM) || (sel_i == ALU_REMU);
        signed_div = (sel_i == ALU_DIV) || (sel_i == ALU_REM);
        div_zero   = (op2_i == '0);
        div_ovf    = signed_div && (op1_i == MIN_VAL) && (op2_i == '1);
        short_cut  = div_op && (div_zero || div_ovf);
        if (div_zero) short_res = rem_op ? op1_i : '1;
        else          short_res = rem_op ? '0 : MIN_VAL;
        go_iter    = muldiv && !short_cut;
        imm_res    = muldiv ? short_res : base_res;
    end

    alu_muldiv_iter #(
        .XLEN  (XLEN),
        .SEL_W (SEL_W)
    ) u_iter (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .start  (accept && go_iter),
        .step   (state == ITER),
        .sel    (sel_i),
        .op1    (op1_i),
        .op2    (op2_i),
        .last   (iter_last),
        .result (iter_result)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= IDLE;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (go_iter) begin
                            state  <= ITER;
                        end else begin
                            result <= imm_res;
                            state  <= DONE;
                        end
                    end
                end
                ITER: if (iter_last) state <= FIX;
                FIX: begin
                    result <= iter_result;
                    state  <= DONE;
                end
                DONE: if (ready_i) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_muldiv.sv
// ============================================================================
// tb_alu_muldiv : directed vectors, handshake corner cases and random compare
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alu_muldiv;
    import alu_muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [4:0]  sel_i = '0;
    logic [31:0] op1_i = '0;
    logic [31:0] op2_i = '0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [31:0] result_o;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [4:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    alu_muldiv #(.XLEN(32), .SEL_W(5)) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .sel_i    (sel_i),
        .op1_i    (op1_i),
        .op2_i    (op2_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .result_o (result_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(logic [4:0] sel, logic [31:0] a, logic [31:0] b);
        logic [63:0] p;
        logic [4:0]  sh;
        int          n;
        sh = b[4:0];
        n  = 0;
        case (sel)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_SLL:  return a << sh;
            ALU_SRL:  return a >> sh;
            ALU_SRA:  return $signed(a) >>> sh;
            ALU_SLT:  return {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: return {31'b0, a < b};
            ALU_XOR:  return a ^ b;
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            ALU_CTZ: begin
                for (int i = 0; i < 32; i++) begin if (a[i]) break; n++; end
                return 32'(n);
            end
            ALU_CLZ: begin
                for (int i = 31; i >= 0; i--) begin if (a[i]) break; n++; end
                return 32'(n);
            end
            ALU_CPOP: return 32'($countones(a));
            ALU_MUL:  begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            ALU_MULH: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
            ALU_MULHSU: begin p = {{32{a[31]}}, a} * {32'b0, b}; return p[63:32]; end
            ALU_MULHU: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            ALU_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return $signed(a) / $signed(b);
            end
            ALU_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return $signed(a) % $signed(b);
            end
            ALU_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            ALU_REMU: return (b == 0) ? a : a % b;
            default:  return 32'h0;
        endcase
    endfunction

    function automatic int model_lat(logic [4:0] sel, logic [31:0] a, logic [31:0] b);
        logic is_sdiv, is_div;
        is_sdiv = (sel == ALU_DIV) || (sel == ALU_REM);
        is_div  = is_sdiv || (sel == ALU_DIVU) || (sel == ALU_REMU);
        if (sel < 5'd16 || sel > 5'd23) return 1;
        if (is_div && (b == 0 || (is_sdiv && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
        return 33;
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] specials [5];
        specials = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    // One transaction; latency counts cycles from the accept edge to valid_o.
    task automatic run_op(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!ready_o && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        valid_i = 1'b1;
        sel_i   = sel;
        op1_i   = a;
        op2_i   = b;
        ready_i = 1'b0;
        @(negedge clk);
        valid_i = 1'b0;
        sel_i   = 5'($urandom);
        op1_i   = $urandom;
        op2_i   = $urandom;
        lat     = 1;
        while (!valid_o && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        res     = result_o;
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
    endtask

    initial begin
        logic [31:0] res;
        logic [31:0] a, b;
        logic [4:0]  sel;
        int          lat;

        vecs.push_back('{ALU_ADD,    32'hFFFF_FFFF, 32'h1,         32'h0,         1});
        vecs.push_back('{ALU_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33});
        vecs.push_back('{ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33});
        vecs.push_back('{ALU_MUL,    32'h7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33});
        vecs.push_back('{ALU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33});
        vecs.push_back('{ALU_DIV,    32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, 33});
        vecs.push_back('{ALU_REM,    32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 33});
        vecs.push_back('{ALU_DIVU,   32'hFFFF_FFFF, 32'h3,         32'h5555_5555, 33});
        vecs.push_back('{ALU_DIVU,   32'h7,         32'h0,         32'hFFFF_FFFF, 1});
        vecs.push_back('{ALU_REMU,   32'h7,         32'h0,         32'h7,         1});
        vecs.push_back('{ALU_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1});
        vecs.push_back('{ALU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
        vecs.push_back('{ALU_CLZ,    32'h0,         32'h0,         32'd32,        1});
        vecs.push_back('{ALU_CTZ,    32'h0001_0000, 32'h0,         32'd16,        1});
        vecs.push_back('{ALU_CPOP,   32'hF0F0_F0F0, 32'h0,         32'd16,        1});
        vecs.push_back('{ALU_SRA,    32'h8000_0000, 32'hFFFF_FFE4, 32'hF800_0000, 1});
        vecs.push_back('{ALU_SLT,    32'hFFFF_FFFF, 32'h1,         32'h1,         1});
        vecs.push_back('{ALU_SLTU,   32'hFFFF_FFFF, 32'h1,         32'h0,         1});
        vecs.push_back('{5'd13,      32'h1,         32'h2,         32'h0,         1});

        repeat (2) @(negedge clk);
        check("reset_state", 64'({ready_o, valid_o, result_o}), 64'({1'b1, 1'b0, 32'h0}));
        rst_i = 1'b0;
        @(negedge clk);
        check("post_reset_idle", 64'({ready_o, valid_o}), 64'(2'b10));

        foreach (vecs[i]) begin
            run_op(vecs[i].sel, vecs[i].a, vecs[i].b, res, lat);
            check($sformatf("vec%0d_result", i), 64'(res), 64'(vecs[i].exp));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
        end

        // Backpressure in DONE with competing requests, then back-to-back accept.
        @(negedge clk);
        valid_i = 1'b1; sel_i = ALU_ADD; op1_i = 32'hFFFF_FFFF; op2_i = 32'h1; ready_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            sel_i = ALU_SUB; op1_i = $urandom; op2_i = $urandom;
            check($sformatf("stall_cycle%0d", i), 64'({ready_o, valid_o, result_o}),
                  64'({1'b0, 1'b1, 32'h0}));
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        check("handoff_idle", 64'({ready_o, valid_o, result_o}), 64'({1'b1, 1'b0, 32'h0}));
        valid_i = 1'b1; sel_i = ALU_XOR; op1_i = 32'h1234_5678; op2_i = 32'h0F0F_0F0F;
        @(negedge clk);
        valid_i = 1'b0;
        check("back_to_back", 64'({valid_o, result_o}), 64'({1'b1, 32'h1D3B_5977}));
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;

        // Reset in the middle of an iterative divide.
        run_op(ALU_ADD, 32'h1, 32'h2, res, lat);
        check("pre_abort_result", 64'(res), 64'(32'h3));
        @(negedge clk);
        valid_i = 1'b1; sel_i = ALU_DIVU; op1_i = 32'd1000; op2_i = 32'd7;
        @(negedge clk);
        valid_i = 1'b0;
        repeat (14) @(negedge clk);
        #2 rst_i = 1'b1;
        #1 check("abort_outputs", 64'({ready_o, valid_o, result_o}), 64'({1'b1, 1'b0, 32'h0}));
        @(negedge clk);
        rst_i = 1'b0;
        run_op(ALU_ADD, 32'd5, 32'd6, res, lat);
        check("after_abort_result", 64'(res), 64'(32'd11));
        check("after_abort_latency", 64'(lat), 64'(1));

        for (int i = 0; i < 200; i++) begin
            sel = 5'($urandom_range(0, 31));
            a   = pick_operand();
            b   = pick_operand();
            run_op(sel, a, b, res, lat);
            check($sformatf("rand%0d_sel%0d_result", i, sel), 64'(res), 64'(model(sel, a, b)));
            check($sformatf("rand%0d_sel%0d_latency", i, sel), 64'(lat), 64'(model_lat(sel, a, b)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
